// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int unsigned MEM_BASE_DEFAULT = 32'd1024;
  localparam int          SRAM_DW          = 16;

  // Selects the half of a 32-bit word that goes out in a given phase.
  function automatic logic [SRAM_DW-1:0] half_word(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side request/response and SRAM pin bundle for the memory stage.
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_AW = 18
);
  // Handshake: mem_read/mem_write are levels raised by the pipeline and held
  // (with alu_res/st_data stable) until ready=1; the pipeline advances at the
  // end of the first cycle in which ready=1, and rdata is valid in that cycle.
  logic                        mem_read;
  logic                        mem_write;
  logic [31:0]                 alu_res;
  logic [31:0]                 st_data;
  logic [31:0]                 rdata;
  logic                        ready;
  logic                        mem_err;
  logic [SRAM_AW-1:0]          sram_addr;
  logic [mem_pkg::SRAM_DW-1:0] sram_dq_in;
  logic [mem_pkg::SRAM_DW-1:0] sram_dq_out;
  logic                        sram_dq_oe;
  logic                        sram_we_n;

  modport master (
    output mem_read, mem_write, alu_res, st_data, sram_dq_in,
    input  rdata, ready, mem_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  mem_read, mem_write, alu_res, st_data, sram_dq_in,
    output rdata, ready, mem_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

endinterface

// File: rtl/mem_stage_sram_ctrl_phase_timer.sv
// Per-phase down-counter: reloads on phase entry, flags the final phase cycle.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last_cycle
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign last_cycle = (count == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: one 32-bit access as two 16-bit SRAM phases (LO, HI).
// Optional MEM_ERR_EN adds an address range check that skips straight to DONE.
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BASE    = MEM_BASE_DEFAULT,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus,
  output mem_state_t            state_dbg
);

  mem_state_t         state, state_nx;
  logic               req;
  logic [31:0]        off;
  logic               addr_err;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        wdata_q;
  logic               is_wr_q;
  logic [31:0]        rdata_q;
  logic               timer_load;
  logic               last_cycle;
  logic               half;
  logic               we_n;
  logic               dq_oe;
  logic               unused_off_lo;

  assign req = bus.mem_read | bus.mem_write;
  assign off = bus.alu_res - MEM_BASE;
  assign unused_off_lo = ^off[1:0];

`ifdef MEM_ERR_EN
  logic err_q;

  assign addr_err = (bus.alu_res < MEM_BASE) | (off[31:SRAM_AW+1] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && req) begin
      err_q <= addr_err;
    end
  end

  assign bus.mem_err = (state == DONE) & err_q;
`else
  logic unused_off_hi;

  // Without the range check, the upper offset bits simply alias.
  assign addr_err      = 1'b0;
  assign unused_off_hi = ^off[31:SRAM_AW+1];
  assign bus.mem_err   = 1'b0;
`endif

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .last_cycle (last_cycle)
  );

  // Request attributes are latched on acceptance so a flushed request still
  // finishes both halves with the original address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        word_q  <= off[SRAM_AW:2];
        wdata_q <= bus.st_data;
        is_wr_q <= bus.mem_write;
      end
      if (!is_wr_q && last_cycle) begin
        if (state == LO) begin
          rdata_q[15:0] <= bus.sram_dq_in;
        end else if (state == HI) begin
          rdata_q[31:16] <= bus.sram_dq_in;
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    timer_load = 1'b0;
    half       = 1'b0;
    we_n       = 1'b1;
    dq_oe      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx   = addr_err ? DONE : LO;
          timer_load = 1'b1;
        end
      end
      LO: begin
        if (is_wr_q) begin
          dq_oe = 1'b1;
          we_n  = last_cycle;
        end
        if (last_cycle) begin
          state_nx   = HI;
          timer_load = 1'b1;
        end
      end
      HI: begin
        half = 1'b1;
        if (is_wr_q) begin
          dq_oe = 1'b1;
          we_n  = last_cycle;
        end
        if (last_cycle) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.ready       = ~req | (state == DONE);
  assign bus.rdata       = rdata_q;
  assign bus.sram_addr   = {word_q, half};
  assign bus.sram_dq_out = half_word(wdata_q, half);
  assign bus.sram_dq_oe  = dq_oe;
  assign bus.sram_we_n   = we_n;
  assign state_dbg       = state;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed accesses against a 16-bit SRAM model,
// with expected SRAM writes and access completions checked from queues.
module tb_mem_stage_sram_ctrl;
  import mem_pkg::*;

  localparam int AW = 18;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] rdata;
    logic        err;
    logic        is_load;
  } done_exp_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_sram_ctrl_if #(.SRAM_AW(AW)) bus ();
  mem_state_t state_dbg;

  mem_stage_sram_ctrl #(
    .MEM_BASE    (1024),
    .WAIT_CYCLES (2),
    .SRAM_AW     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- SRAM model ----------------
  logic [15:0]   sram_mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [15:0]   pre_data = '0;

  assign bus.sram_dq_in = bus.sram_dq_oe ? 16'h0000 : sram_mem[bus.sram_addr];

  always @(posedge clk) begin
    if (pre_en) sram_mem[pre_addr] <= pre_data;
    else if (!bus.sram_we_n && bus.sram_dq_oe) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
  end

  // ---------------- scoreboard state ----------------
  wr_exp_t     wr_q[$];
  done_exp_t   done_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic        cur_load = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] last_exp_cyc = '0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  initial begin
    wr_exp_t   w;
    done_exp_t d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!bus.sram_we_n) begin
          if (wr_q.size() == 0) begin
            fail_now("unexpected_write");
          end else begin
            w = wr_q.pop_front();
            check("wr_addr", 32'(bus.sram_addr), 32'(w.addr));
            check("wr_data", 32'(bus.sram_dq_out), 32'(w.data));
            check("wr_oe", 32'(bus.sram_dq_oe), 32'd1);
          end
        end
        if (cur_load && (!bus.sram_we_n || bus.sram_dq_oe)) stray = 1'b1;
        if (state_dbg == DONE) begin
          if (done_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            d = done_q.pop_front();
            check("done_cycle", cyc, d.cyc);
            check("done_ready", 32'(bus.ready), 32'd1);
            check("done_rdata", bus.rdata, d.rdata);
            check("done_mem_err", 32'(bus.mem_err), 32'(d.err));
            if (d.is_load) check("load_no_strobe", 32'(stray), 32'd0);
            stray = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic push_store_writes(input logic [AW-1:0] a_lo, input logic [31:0] d);
    wr_q.push_back('{addr: a_lo,        data: d[15:0]});
    wr_q.push_back('{addr: a_lo,        data: d[15:0]});
    wr_q.push_back('{addr: a_lo + 18'd1, data: d[31:16]});
    wr_q.push_back('{addr: a_lo + 18'd1, data: d[31:16]});
  endtask

  // Raises a request in a fresh cycle ("cycle 0") and queues its completion.
  task automatic start_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input int lat, input logic [31:0] exp_rd, input logic exp_err,
                              input logic expect_done);
    @(posedge clk);
    #1;
    bus.mem_read  = !wr;
    bus.mem_write = wr;
    bus.alu_res   = addr;
    bus.st_data   = data;
    cur_load      = !wr;
    last_exp_cyc  = cyc + 32'(lat);
    if (expect_done)
      done_q.push_back('{cyc: cyc + 32'(lat), rdata: exp_rd, err: exp_err, is_load: !wr});
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus.ready && n < 20);
    if (!bus.ready) fail_now("ready_timeout");
    else check("ready_cycle", cyc, last_exp_cyc);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_rd);
    start_access(1'b0, addr, 32'h0, 7, exp_rd, 1'b0, 1'b1);
    model_rdata = exp_rd;
    wait_ready();
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [AW-1:0] a_lo);
    push_store_writes(a_lo, data);
    start_access(1'b1, addr, data, 7, model_rdata, 1'b0, 1'b1);
    wait_ready();
  endtask

  task automatic idle_bus();
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    cur_load      = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_res   = '0;
    bus.st_data   = '0;
    preload(18'd2, 16'h1234);
    preload(18'd3, 16'h5678);
    preload(18'h3FE32, 16'hA5A5);
    preload(18'h3FE33, 16'h5A5A);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("rst_addr", 32'(bus.sram_addr), 32'd0);
    check("rst_mem_err", 32'(bus.mem_err), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    mon_en = 1'b1;

    // store then back-to-back loads; low address bits are ignored
    do_store(32'd1024, 32'hDEADBEEF, 18'd0);
    do_load(32'd1024, 32'hDEADBEEF);
    do_load(32'd1028, 32'h56781234);
    do_store(32'd1030, 32'h0BADF00D, 18'd2);
    do_load(32'd1028, 32'h0BADF00D);
    idle_bus();

    // request dropped in cycle 2: both halves still written
    push_store_writes(18'd4, 32'hCAFE0001);
    start_access(1'b1, 32'd1032, 32'hCAFE0001, 7, model_rdata, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("flush_idle_state", 32'(state_dbg), 32'(IDLE));
    check("flush_idle_ready", 32'(bus.ready), 32'd1);
    do_load(32'd1032, 32'hCAFE0001);

    // out-of-window address
`ifdef MEM_ERR_EN
    start_access(1'b0, 32'd100, 32'h0, 1, model_rdata, 1'b1, 1'b1);
    wait_ready();
`else
    do_load(32'd100, 32'h5A5AA5A5);
`endif
    idle_bus();

    // reset in cycle 4 of a store: LO written, first HI strobe seen
    wr_q.push_back('{addr: 18'd8, data: 16'h2222});
    wr_q.push_back('{addr: 18'd8, data: 16'h2222});
    wr_q.push_back('{addr: 18'd9, data: 16'h1111});
    start_access(1'b1, 32'd1040, 32'h11112222, 7, model_rdata, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.mem_write = 1'b0;
    cur_load      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    check("midrst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("midrst_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("midrst_rdata", bus.rdata, 32'h0);
    model_rdata = '0;

    do_load(32'd1024, 32'hDEADBEEF);
    idle_bus();
    repeat (4) @(posedge clk);
    #1;
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
